// File: rtl/fmcw_pkg.sv
// Shared constants and host-word layout for the FMCW receive-path capture control.
// Build option: FMCW_RAW_ADC_EN (consumed in fmcw_capture_ctrl) places the raw
// ADC sample into the host word; otherwise that field is zero.
package fmcw_pkg;

   localparam int unsigned FFT_N            = 1024;
   localparam int unsigned N_WIDTH          = $clog2(FFT_N);
   localparam int unsigned FFT_N_LAST       = FFT_N - 1;
   localparam int unsigned ADC_DATA_WIDTH   = 12;
   localparam int unsigned FIR_OUTPUT_WIDTH = 14;
   localparam int unsigned CLK_DIV          = 20;
   localparam int unsigned CLK_DIV_WIDTH    = $clog2(CLK_DIV);
   localparam int unsigned HOST_WIDTH       = 64;
   localparam int unsigned HOST_HDR_WIDTH   = 4;
   localparam int unsigned HOST_TAIL_WIDTH  = 8;
   localparam int unsigned HOST_PAD_WIDTH   = HOST_WIDTH - HOST_HDR_WIDTH - FIR_OUTPUT_WIDTH
                                              - ADC_DATA_WIDTH - HOST_TAIL_WIDTH;

   localparam logic [HOST_HDR_WIDTH-1:0] HOST_HDR = 4'b1000;

   // Host FIFO word, MSB first.
   typedef struct packed {
      logic [HOST_HDR_WIDTH-1:0]   hdr;
      logic [HOST_PAD_WIDTH-1:0]   pad;
      logic [FIR_OUTPUT_WIDTH-1:0] fir;
      logic [ADC_DATA_WIDTH-1:0]   adc;
      logic [HOST_TAIL_WIDTH-1:0]  tail;
   } host_word_t;

endpackage

// File: rtl/fmcw_capture_ctrl_if.sv
// Bus bundle between fmcw_capture_ctrl and its surroundings (ADC, FIR, FFT, USB FIFO).
// master: the capture controller; slave: the environment driving samples/status.
interface fmcw_capture_ctrl_if;
   import fmcw_pkg::*;

   logic signed [ADC_DATA_WIDTH-1:0]   adc_d_i;
   logic signed [FIR_OUTPUT_WIDTH-1:0] fir_din_i;
   logic                               fir_dvalid_i;
   logic [N_WIDTH-1:0]                 fft_ctr_i;
   logic                               wrfifo_full_i;

   logic                               sample_en_o;
   logic [1:0]                         adc_oe_o;
   logic [1:0]                         adc_shdn_o;
   logic                               mix_enbl_n_o;
   logic                               pa_en_n_o;
   logic                               led_o;
   logic                               fft_en_o;
   logic [FIR_OUTPUT_WIDTH-1:0]        fft_data_o;
   logic                               host_wren_o;
   logic [HOST_WIDTH-1:0]              host_wrdata_o;

   modport master (
      input  adc_d_i, fir_din_i, fir_dvalid_i, fft_ctr_i, wrfifo_full_i,
      output sample_en_o, adc_oe_o, adc_shdn_o, mix_enbl_n_o, pa_en_n_o, led_o,
             fft_en_o, fft_data_o, host_wren_o, host_wrdata_o
   );

   modport slave (
      output adc_d_i, fir_din_i, fir_dvalid_i, fft_ctr_i, wrfifo_full_i,
      input  sample_en_o, adc_oe_o, adc_shdn_o, mix_enbl_n_o, pa_en_n_o, led_o,
             fft_en_o, fft_data_o, host_wren_o, host_wrdata_o
   );

endinterface

// File: rtl/capture_ram.sv
// One-frame sample buffer: simple dual-port, registered read, read-first on collision.
// Ports: clk_i, rst_n (clears the read register only), wr_en/wr_addr/wr_data,
//        rd_addr, rd_data.
module capture_ram
   import fmcw_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [N_WIDTH-1:0]          wr_addr,
   input  logic [FIR_OUTPUT_WIDTH-1:0] wr_data,
   input  logic [N_WIDTH-1:0]          rd_addr,
   output logic [FIR_OUTPUT_WIDTH-1:0] rd_data
);

   logic [FIR_OUTPUT_WIDTH-1:0] mem [FFT_N];

   // Storage is never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Non-blocking read of the pre-write array gives read-first behaviour.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fmcw_capture_ctrl.sv
// FMCW receive-path control: 2 MHz sample strobe, front-end enables, one-frame
// FIR capture buffer, FFT window generation and host FIFO word formatting.
// Ports: clk_i (40 MHz), rst_n (async, active-low, PLL lock), bus (master modport
//        of fmcw_capture_ctrl_if carrying all ADC/FIR/FFT/host signals).
// Build option: FMCW_RAW_ADC_EN puts adc_d_i into host_wrdata_o[19:8].
module fmcw_capture_ctrl
   import fmcw_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n,
   fmcw_capture_ctrl_if.master  bus
);

   logic [CLK_DIV_WIDTH-1:0] div_ctr;
   logic                     sample_en_q;
   logic [1:0]               adc_ctl_q;
   logic [N_WIDTH-1:0]       wr_ctr;
   logic [N_WIDTH-1:0]       rd_ctr;
   logic                     fft_en_q;
   logic                     wr_fire;
   host_word_t               host_word;

   // Sample strobe divider.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         div_ctr     <= '0;
         sample_en_q <= 1'b0;
      end else if (div_ctr == CLK_DIV_WIDTH'(CLK_DIV - 1)) begin
         div_ctr     <= '0;
         sample_en_q <= 1'b1;
      end else begin
         div_ctr     <= div_ctr + CLK_DIV_WIDTH'(1);
         sample_en_q <= 1'b0;
      end
   end

   // ADC stays disabled/shut down until the first edge after PLL lock.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         adc_ctl_q <= 2'b11;
      end else begin
         adc_ctl_q <= 2'b00;
      end
   end

   assign wr_fire = sample_en_q & bus.fir_dvalid_i;

   // Capture write pointer.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ctr <= '0;
      end else if (wr_fire) begin
         wr_ctr <= (wr_ctr == N_WIDTH'(FFT_N_LAST)) ? '0 : wr_ctr + N_WIDTH'(1);
      end
   end

   // FFT window: FFT-side terminal count closes it ahead of the capture-side opener.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         fft_en_q <= 1'b0;
      end else if (bus.fft_ctr_i == N_WIDTH'(FFT_N - 2)) begin
         fft_en_q <= 1'b0;
      end else if (wr_ctr == N_WIDTH'(FFT_N - 2)) begin
         fft_en_q <= 1'b1;
      end
   end

   // Read pointer parks at 0 outside the window.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rd_ctr <= '0;
      end else if (!fft_en_q) begin
         rd_ctr <= '0;
      end else begin
         rd_ctr <= rd_ctr + N_WIDTH'(1);
      end
   end

   capture_ram u_capture_ram (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .wr_en   (wr_fire),
      .wr_addr (wr_ctr),
      .wr_data (bus.fir_din_i),
      .rd_addr (rd_ctr),
      .rd_data (bus.fft_data_o)
   );

   // Host word assembly.
   always_comb begin
      host_word     = '0;
      host_word.hdr = HOST_HDR;
      host_word.fir = bus.fir_din_i;
`ifdef FMCW_RAW_ADC_EN
      host_word.adc = bus.adc_d_i;
`endif
   end

`ifndef FMCW_RAW_ADC_EN
   // Raw ADC field is blanked in this build.
   logic adc_unused;
   assign adc_unused = ^bus.adc_d_i;
`endif

   assign bus.sample_en_o   = sample_en_q;
   assign bus.adc_oe_o      = adc_ctl_q;
   assign bus.adc_shdn_o    = adc_ctl_q;
   // RF front end follows PLL lock directly, without waiting for a clock edge.
   assign bus.mix_enbl_n_o  = ~rst_n;
   assign bus.pa_en_n_o     = ~rst_n;
   assign bus.led_o         = rst_n;
   assign bus.fft_en_o      = fft_en_q;
   // Full FIFO drops the sample.
   assign bus.host_wren_o   = sample_en_q & ~bus.wrfifo_full_i;
   assign bus.host_wrdata_o = host_word;

endmodule

// File: tb/tb_fmcw_capture_ctrl.sv
// Self-checking bench for fmcw_capture_ctrl: captured samples and host words are
// queued when driven and compared when the DUT presents them.
module tb_fmcw_capture_ctrl;
   import fmcw_pkg::*;

   logic clk_i = 1'b0;
   logic rst_n;

   fmcw_capture_ctrl_if bus ();

   fmcw_capture_ctrl dut (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

`ifdef FMCW_RAW_ADC_EN
   localparam logic [11:0] ADC_MASK = 12'hFFF;
`else
   localparam logic [11:0] ADC_MASK = 12'h000;
`endif

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   logic [FIR_OUTPUT_WIDTH-1:0] exp_q [$];
   logic [HOST_WIDTH-1:0]       host_q [$];
   int unsigned n_wr    = 0;
   int unsigned wr_stop = 0;
   bit          wr_pend = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [63:0] act);
      logic [63:0] e;
      e = (exp_q.size() == 0) ? 64'hx : 64'(exp_q.pop_front());
      check_val(tag, act, e);
   endtask

   function automatic logic [63:0] host_exp(input logic [13:0] fir, input logic [11:0] adc);
      return {4'b1000, 26'd0, fir, adc & ADC_MASK, 8'h00};
   endfunction

   // One clock; tracks capture writes and pushes the sample the DUT is about to store.
   task automatic step();
      @(posedge clk_i);
      #1;
      if (wr_pend) begin
         wr_pend = 1'b0;
         n_wr++;
         if (n_wr == wr_stop) bus.fir_dvalid_i = 1'b0;
         else                 bus.fir_din_i = FIR_OUTPUT_WIDTH'(bus.fir_din_i + 14'sd1);
      end
      if (bus.sample_en_o && bus.fir_dvalid_i) begin
         exp_q.push_back(bus.fir_din_i);
         wr_pend = 1'b1;
      end
   endtask

   task automatic start_capture(input logic [13:0] d, input int unsigned nwrites);
      if (bus.sample_en_o) step();
      bus.fir_din_i    = d;
      wr_stop          = n_wr + nwrites;
      bus.fir_dvalid_i = 1'b1;
   endtask

   task automatic wait_strobe(input string tag);
      int unsigned g = 0;
      do begin
         step();
         g++;
      end while (!bus.sample_en_o && g < 40);
      if (!bus.sample_en_o) check_val(tag, 64'(bus.sample_en_o), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] fir_pat [3];
      logic [11:0] adc_pat [3];
      int unsigned guard;

      fir_pat[0] = 14'h1ABC; adc_pat[0] = 12'h123;
      fir_pat[1] = 14'h3FFF; adc_pat[1] = 12'hFFF;
      fir_pat[2] = 14'h0001; adc_pat[2] = 12'h800;

      rst_n             = 1'b0;
      bus.adc_d_i       = '0;
      bus.fir_din_i     = '0;
      bus.fir_dvalid_i  = 1'b0;
      bus.fft_ctr_i     = '0;
      bus.wrfifo_full_i = 1'b0;

      // Reset state
      repeat (3) step();
      check_val("rst_sample_en", 64'(bus.sample_en_o), 64'd0);
      check_val("rst_fft_en",    64'(bus.fft_en_o),    64'd0);
      check_val("rst_fft_data",  64'(bus.fft_data_o),  64'd0);
      check_val("rst_adc_oe",    64'(bus.adc_oe_o),    64'd3);
      check_val("rst_adc_shdn",  64'(bus.adc_shdn_o),  64'd3);
      check_val("rst_mix",       64'(bus.mix_enbl_n_o), 64'd1);
      check_val("rst_pa",        64'(bus.pa_en_n_o),   64'd1);
      check_val("rst_led",       64'(bus.led_o),       64'd0);
      check_val("rst_wren",      64'(bus.host_wren_o), 64'd0);

      // Release: front end enables at once, ADC on the next edge, strobe every 20 edges
      #2 rst_n = 1'b1;
      #1;
      check_val("rel_mix",    64'(bus.mix_enbl_n_o), 64'd0);
      check_val("rel_pa",     64'(bus.pa_en_n_o),    64'd0);
      check_val("rel_led",    64'(bus.led_o),        64'd1);
      check_val("rel_adc_oe", 64'(bus.adc_oe_o),     64'd3);
      for (int c = 1; c <= 100; c++) begin
         step();
         check_val("strobe", 64'(bus.sample_en_o), 64'(c % 20 == 0));
         if (c == 1) begin
            check_val("adc_oe_on",   64'(bus.adc_oe_o),   64'd0);
            check_val("adc_shdn_on", 64'(bus.adc_shdn_o), 64'd0);
         end
      end

      // Ramp capture; window opens one edge after the 1022nd write
      start_capture(14'd0, 1024);
      guard = 0;
      while (n_wr < 1022 && guard < 30000) begin
         step();
         guard++;
      end
      if (n_wr < 1022) check_val("capture_timeout", 64'(n_wr), 64'd1022);
      check_val("en_before", 64'(bus.fft_en_o), 64'd0);
      step();
      check_val("en_rise", 64'(bus.fft_en_o), 64'd1);
      for (int k = 0; k < 1024; k++) begin
         step();
         check_pop("readout", 64'(bus.fft_data_o));
      end

      // Close window; read pointer parks at 0 (buf[0] = 0)
      bus.fft_ctr_i = 10'd1022;
      step();
      check_val("en_clear", 64'(bus.fft_en_o), 64'd0);
      bus.fft_ctr_i = 10'd0;
      step();
      step();
      repeat (3) begin
         step();
         check_val("rd_home", 64'(bus.fft_data_o), 64'd0);
      end

      // Pointer wrapped after 1024 writes: next write lands in buf[0]
      exp_q.delete();
      start_capture(14'h2A5A, 1);
      guard = 0;
      while (!wr_pend && guard < 40) begin
         step();
         guard++;
      end
      if (!wr_pend) check_val("wrap_timeout", 64'(bus.sample_en_o), 64'd1);
      step();
      check_val("read_first", 64'(bus.fft_data_o), 64'd0);
      step();
      check_pop("wrap_wr0", 64'(bus.fft_data_o));

      // Clear has priority while wr_ctr sits at 1022
      exp_q.delete();
      bus.fft_ctr_i = 10'd1022;
      start_capture(14'd100, 1021);
      guard = 0;
      while (n_wr < wr_stop && guard < 25000) begin
         step();
         guard++;
      end
      if (n_wr < wr_stop) check_val("prio_timeout", 64'(n_wr), 64'(wr_stop));
      repeat (10) begin
         step();
         check_val("clr_prio", 64'(bus.fft_en_o), 64'd0);
      end
      bus.fft_ctr_i = 10'd0;
      step();
      check_val("en_set", 64'(bus.fft_en_o), 64'd1);

      // Host words
      exp_q.delete();
      bus.wrfifo_full_i = 1'b1;
      wait_strobe("full_strobe_timeout");
      check_val("wren_full", 64'(bus.host_wren_o), 64'd0);
      bus.wrfifo_full_i = 1'b0;
      for (int p = 0; p < 3; p++) begin
         bus.fir_din_i = fir_pat[p];
         bus.adc_d_i   = adc_pat[p];
         host_q.push_back(host_exp(fir_pat[p], adc_pat[p]));
         wait_strobe("host_strobe_timeout");
         check_val("wren", 64'(bus.host_wren_o), 64'd1);
         check_val("wrdata", bus.host_wrdata_o,
                   (host_q.size() == 0) ? 64'hx : host_q.pop_front());
      end

      // Asynchronous reset mid-window, taken while the strobe is high
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_fft_en",    64'(bus.fft_en_o),     64'd0);
      check_val("arst_sample_en", 64'(bus.sample_en_o),  64'd0);
      check_val("arst_fft_data",  64'(bus.fft_data_o),   64'd0);
      check_val("arst_mix",       64'(bus.mix_enbl_n_o), 64'd1);
      check_val("arst_adc_oe",    64'(bus.adc_oe_o),     64'd3);
      repeat (2) step();
      n_wr    = 0;
      wr_pend = 1'b0;
      start_capture(14'h0555, 1);
      #2 rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         check_val("strobe_rel", 64'(bus.sample_en_o), 64'(c == 20));
      end
      step();
      check_val("buf_keep", 64'(bus.fft_data_o), 64'h2A5A);
      step();
      check_pop("wr_reset", 64'(bus.fft_data_o));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
